// File: rtl/line_window_buffer5x5.sv
// Streaming 5x5 sliding-window generator: four line buffers feed a 5x5 register window, valid-only windows.
// Optional macro LWB_OUT_COORD_EN adds registered out_row/out_col window coordinates.
module line_window_buffer5x5 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8
`ifdef LWB_OUT_COORD_EN
    ,
    localparam int OROW_W = (IMG_H - 4 > 1) ? $clog2(IMG_H - 4) : 1,
    localparam int OCOL_W = (IMG_W - 4 > 1) ? $clog2(IMG_W - 4) : 1
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic [DATA_W-1:0] data_out_3,
    output logic [DATA_W-1:0] data_out_4,
    output logic [DATA_W-1:0] data_out_5,
    output logic [DATA_W-1:0] data_out_6,
    output logic [DATA_W-1:0] data_out_7,
    output logic [DATA_W-1:0] data_out_8,
    output logic [DATA_W-1:0] data_out_9,
    output logic [DATA_W-1:0] data_out_10,
    output logic [DATA_W-1:0] data_out_11,
    output logic [DATA_W-1:0] data_out_12,
    output logic [DATA_W-1:0] data_out_13,
    output logic [DATA_W-1:0] data_out_14,
    output logic [DATA_W-1:0] data_out_15,
    output logic [DATA_W-1:0] data_out_16,
    output logic [DATA_W-1:0] data_out_17,
    output logic [DATA_W-1:0] data_out_18,
    output logic [DATA_W-1:0] data_out_19,
    output logic [DATA_W-1:0] data_out_20,
    output logic [DATA_W-1:0] data_out_21,
    output logic [DATA_W-1:0] data_out_22,
    output logic [DATA_W-1:0] data_out_23,
    output logic [DATA_W-1:0] data_out_24,
    output logic              valid_out_buf,
    output logic              frame_done
`ifdef LWB_OUT_COORD_EN
    ,
    output logic [OROW_W-1:0] out_row,
    output logic [OCOL_W-1:0] out_col
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(4);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(4);

    logic [COL_W-1:0]  r_col_cnt;
    logic [ROW_W-1:0]  r_row_cnt;
    logic [DATA_W-1:0] r_line [4][IMG_W];
    logic [DATA_W-1:0] r_win  [5][5];
    logic              r_valid_out;
    logic              r_frame_done;

    logic w_col_wrap;
    logic w_row_wrap;
    logic w_win_ready;

    assign w_col_wrap  = (r_col_cnt == COL_LAST);
    assign w_row_wrap  = (r_row_cnt == ROW_LAST);
    assign w_win_ready = (r_row_cnt >= ROW_FIRST) && (r_col_cnt >= COL_FIRST);

    // NOTE: line buffers carry no reset so they can map onto RAM; stale contents never reach a valid window.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int k = 0; k < 3; k++) begin
                r_line[k][r_col_cnt] <= r_line[k+1][r_col_cnt];
            end
            r_line[3][r_col_cnt] <= pix_in;
        end
    end

    // NOTE: all state updates are non-blocking so every read below sees the pre-edge line buffer and window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_valid_out  <= pix_valid && w_win_ready;
            r_frame_done <= pix_valid && w_col_wrap && w_row_wrap;
            if (pix_valid) begin
                if (w_col_wrap) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_wrap ? '0 : r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        r_win[i][j] <= r_win[i][j+1];
                    end
                end
                // Column 4 of rows 0..3 comes from the same column 4..1 rows back.
                for (int i = 0; i < 4; i++) begin
                    r_win[i][4] <= r_line[i][r_col_cnt];
                end
                r_win[4][4] <= pix_in;
            end
        end
    end

`ifdef LWB_OUT_COORD_EN
    logic [OROW_W-1:0] r_out_row;
    logic [OCOL_W-1:0] r_out_col;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_row <= '0;
            r_out_col <= '0;
        end else if (pix_valid && w_win_ready) begin
            r_out_row <= OROW_W'(r_row_cnt - ROW_FIRST);
            r_out_col <= OCOL_W'(r_col_cnt - COL_FIRST);
        end
    end

    assign out_row = r_out_row;
    assign out_col = r_out_col;
`endif

    assign valid_out_buf = r_valid_out;
    assign frame_done    = r_frame_done;

    assign data_out_0  = r_win[0][0];
    assign data_out_1  = r_win[0][1];
    assign data_out_2  = r_win[0][2];
    assign data_out_3  = r_win[0][3];
    assign data_out_4  = r_win[0][4];
    assign data_out_5  = r_win[1][0];
    assign data_out_6  = r_win[1][1];
    assign data_out_7  = r_win[1][2];
    assign data_out_8  = r_win[1][3];
    assign data_out_9  = r_win[1][4];
    assign data_out_10 = r_win[2][0];
    assign data_out_11 = r_win[2][1];
    assign data_out_12 = r_win[2][2];
    assign data_out_13 = r_win[2][3];
    assign data_out_14 = r_win[2][4];
    assign data_out_15 = r_win[3][0];
    assign data_out_16 = r_win[3][1];
    assign data_out_17 = r_win[3][2];
    assign data_out_18 = r_win[3][3];
    assign data_out_19 = r_win[3][4];
    assign data_out_20 = r_win[4][0];
    assign data_out_21 = r_win[4][1];
    assign data_out_22 = r_win[4][2];
    assign data_out_23 = r_win[4][3];
    assign data_out_24 = r_win[4][4];

endmodule

// File: tb/tb_line_window_buffer5x5.sv
// Scoreboard bench for line_window_buffer5x5: a reference image model queues expected windows per accepted pixel.
module tb_line_window_buffer5x5;

    localparam int W = 28;
    localparam int H = 28;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_in = 8'h00;
    logic [7:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
    logic [7:0] data_out_5, data_out_6, data_out_7, data_out_8, data_out_9;
    logic [7:0] data_out_10, data_out_11, data_out_12, data_out_13, data_out_14;
    logic [7:0] data_out_15, data_out_16, data_out_17, data_out_18, data_out_19;
    logic [7:0] data_out_20, data_out_21, data_out_22, data_out_23, data_out_24;
    logic       valid_out_buf;
    logic       frame_done;
`ifdef LWB_OUT_COORD_EN
    logic [4:0] out_row;
    logic [4:0] out_col;
`endif

    always #5 clk = ~clk;

    line_window_buffer5x5 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
        .data_out_6(data_out_6), .data_out_7(data_out_7), .data_out_8(data_out_8),
        .data_out_9(data_out_9), .data_out_10(data_out_10), .data_out_11(data_out_11),
        .data_out_12(data_out_12), .data_out_13(data_out_13), .data_out_14(data_out_14),
        .data_out_15(data_out_15), .data_out_16(data_out_16), .data_out_17(data_out_17),
        .data_out_18(data_out_18), .data_out_19(data_out_19), .data_out_20(data_out_20),
        .data_out_21(data_out_21), .data_out_22(data_out_22), .data_out_23(data_out_23),
        .data_out_24(data_out_24),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done)
`ifdef LWB_OUT_COORD_EN
        , .out_row(out_row), .out_col(out_col)
`endif
    );

    logic [199:0] act_taps;
    assign act_taps = {data_out_24, data_out_23, data_out_22, data_out_21, data_out_20,
                       data_out_19, data_out_18, data_out_17, data_out_16, data_out_15,
                       data_out_14, data_out_13, data_out_12, data_out_11, data_out_10,
                       data_out_9,  data_out_8,  data_out_7,  data_out_6,  data_out_5,
                       data_out_4,  data_out_3,  data_out_2,  data_out_1,  data_out_0};

    typedef struct {
        logic [199:0] taps;
        int           orow;
        int           ocol;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   img [H][W];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           mr = 0;
    int           mc = 0;
    int           m_orow = 0;
    int           m_ocol = 0;
    int           accepted = 0;
    int           valid_cnt = 0;
    int           fd_cnt = 0;
    int           row_valids [H];
    int           fd_at[$];
    logic [199:0] first_win[$];
    logic [199:0] last_taps;

    function automatic logic [7:0] pix_of(input int mode, input int r, input int c);
        if (mode == 1) return 8'h80;
        return 8'((r * W + c) % 128);
    endfunction

    task automatic clear_stats();
        valid_cnt = 0;
        fd_cnt    = 0;
        fd_at.delete();
        first_win.delete();
        for (int r = 0; r < H; r++) row_valids[r] = 0;
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        m_orow = 0;
        m_ocol = 0;
        sb.delete();
    endtask

    // One clock: drive, update the model, then check outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] px);
        exp_t e;
        logic exp_valid;
        logic exp_fd;
        pix_valid = v;
        pix_in    = px;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            img[mr][mc] = px;
            accepted++;
            if (mr >= 4 && mc >= 4) begin
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.taps[8*(5*i+j) +: 8] = img[mr-4+i][mc-4+j];
                e.orow = mr - 4;
                e.ocol = mc - 4;
                m_orow = e.orow;
                m_ocol = e.ocol;
                sb.push_back(e);
                exp_valid = 1'b1;
            end
            exp_fd = (mr == H - 1) && (mc == W - 1);
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (valid_out_buf !== exp_valid) begin
            n_fail++;
            $display("FAIL valid_out_buf: got %b expected %b (accepted=%0d)", valid_out_buf, exp_valid, accepted);
        end
        n_assert++;
        if (frame_done !== exp_fd) begin
            n_fail++;
            $display("FAIL frame_done: got %b expected %b (accepted=%0d)", frame_done, exp_fd, accepted);
        end
`ifdef LWB_OUT_COORD_EN
        n_assert++;
        if (out_row !== 5'(m_orow) || out_col !== 5'(m_ocol)) begin
            n_fail++;
            $display("FAIL coord: got (%0d,%0d) expected (%0d,%0d)", out_row, out_col, m_orow, m_ocol);
        end
`endif
        if (valid_out_buf === 1'b1) begin
            valid_cnt++;
            last_taps = act_taps;
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL window_unexpected: got valid with empty scoreboard, required none");
            end else begin
                e = sb.pop_front();
                row_valids[e.orow]++;
                if (e.orow == 0 && e.ocol == 0) first_win.push_back(act_taps);
                n_assert++;
                if (act_taps !== e.taps) begin
                    n_fail++;
                    $display("FAIL window(%0d,%0d): got %h expected %h", e.orow, e.ocol, act_taps, e.taps);
                end
            end
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_at.push_back(accepted);
        end
    endtask

    task automatic send_pixels(input int mode, input int n, input int gap_pct);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < gap_pct) step(1'b0, 8'($urandom));
            step(1'b1, pix_of(mode, mr, mc));
        end
        step(1'b0, 8'h00);
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_first_window(input string tag);
        logic [199:0] fw;
        expect_int({tag, "_first_window_present"}, first_win.size() > 0 ? 1 : 0, 1);
        if (first_win.size() > 0) begin
            fw = first_win[0];
            expect_int({tag, "_tap0"},  int'(fw[7:0]),     0);
            expect_int({tag, "_tap4"},  int'(fw[39:32]),   4);
            expect_int({tag, "_tap20"}, int'(fw[167:160]), 112);
            expect_int({tag, "_tap24"}, int'(fw[199:192]), 116);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_valid = 1'b1;
        pix_in = 8'h5a;
        repeat (2) @(posedge clk);
        #1;
        expect_int("reset_valid", int'(valid_out_buf), 0);
        expect_int("reset_frame_done", int'(frame_done), 0);
        n_assert++;
        if (act_taps !== '0) begin
            n_fail++;
            $display("FAIL reset_taps: got %h expected all zero", act_taps);
        end
        rst_n = 1'b1;
        pix_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_ramp_frame();
        clear_stats();
        send_pixels(0, W * H, 0);
        expect_int("ramp_valid_count", valid_cnt, 576);
        expect_int("ramp_frame_done_count", fd_cnt, 1);
        expect_int("ramp_last_tap24", int'(last_taps[199:192]), 15);
        check_first_window("ramp");
        for (int r = 0; r < H - 4; r++) expect_int("row_edge_valids", row_valids[r], 24);
    endtask

    task automatic test_negative_frame();
        clear_stats();
        send_pixels(1, W * H, 0);
        expect_int("neg_valid_count", valid_cnt, 576);
        expect_int("neg_last_tap0", int'(last_taps[7:0]), 128);
        expect_int("neg_last_tap12", int'(last_taps[103:96]), 128);
    endtask

    task automatic test_gaps();
        clear_stats();
        send_pixels(0, W * H, 50);
        expect_int("gaps_valid_count", valid_cnt, 576);
        expect_int("gaps_frame_done_count", fd_cnt, 1);
        check_first_window("gaps");
    endtask

    task automatic test_reset_mid_frame();
        send_pixels(0, 300, 0);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        expect_int("midrst_valid", int'(valid_out_buf), 0);
        n_assert++;
        if (act_taps !== '0) begin
            n_fail++;
            $display("FAIL midrst_taps: got %h expected all zero", act_taps);
        end
        rst_n = 1'b1;
        model_reset();
        clear_stats();
        send_pixels(0, W * H, 0);
        expect_int("midrst_valid_count", valid_cnt, 576);
        check_first_window("midrst");
    endtask

    task automatic test_back_to_back();
        logic [199:0] w0;
        logic [199:0] w1;
        clear_stats();
        send_pixels(0, 2 * W * H, 0);
        expect_int("b2b_valid_count", valid_cnt, 1152);
        expect_int("b2b_frame_done_count", fd_cnt, 2);
        if (fd_at.size() == 2) expect_int("b2b_frame_done_spacing", fd_at[1] - fd_at[0], W * H);
        expect_int("b2b_first_windows", first_win.size(), 2);
        if (first_win.size() == 2) begin
            w0 = first_win[0];
            w1 = first_win[1];
            n_assert++;
            if (w1 !== w0) begin
                n_fail++;
                $display("FAIL b2b_first_window: got %h expected %h", w1, w0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_negative_frame();
        test_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        expect_int("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
